alu_scheduler: RTL and testbench

Round-robin scheduler sharing the single pipelined `alu32` between up to `ninputs` requesters: speed PIDs, the position loop and the odometry block. It replaces the free-running `keymux` feed. It accepts one operation per cycle over a valid/ready handshake and tags each operation with a key identifying its requester. It routes each keyed ALU result back to its owner, allows one outstanding operation per requester, and uses a timeout watchdog to recover lost results.

---
 rtl/alu_scheduler_pkg.sv | 23 ++
 rtl/alu_scheduler_rr_arbiter.sv | 58 +++++
 rtl/alu_scheduler.sv | 130 +++++++++++++
 tb/tb_alu_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_scheduler_pkg.sv
// Shared widths, opcodes and key helper for the ALU scheduler and its requesters.
// KEY_SIZE = 3 leaves room for up to six requesters plus the idle key and one spare.
package alu_scheduler_pkg;

    localparam int unsigned KEY_SIZE     = 3;
    localparam int unsigned OPCODE_SIZE  = 4;
    localparam int unsigned OPERAND_SIZE = 32;
    localparam int unsigned ALU_TIMEOUT  = 16;

    typedef enum logic [OPCODE_SIZE-1:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4
    } alu_op_e;

    // Requester i owns key i+1; key 0 marks an idle ALU slot.
    function automatic logic [KEY_SIZE-1:0] key_of(input int unsigned idx);
        return KEY_SIZE'(idx + 1);
    endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping.
// ptr moves past the winner only when the caller reports that the grant was taken.
module rr_arbiter #(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [n-1:0] req,
    input  logic         advance,
    output logic [n-1:0] grant
);

    localparam int unsigned PtrW = (n > 1) ? $clog2(n) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [n-1:0]    upper;
    logic            found;

    always_comb begin
        grant = '0;
        upper = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        for (int i = 0; i < int'(n); i++) begin
            upper[i] = req[i] && (i >= int'(ptr_q));
        end
        // Requests at or above ptr first, then wrap to the bottom.
        for (int i = 0; i < int'(n); i++) begin
            if (!found && upper[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                ptr_d    = PtrW'((i + 1) % int'(n));
            end
        end
        for (int i = 0; i < int'(n); i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                ptr_d    = PtrW'((i + 1) % int'(n));
            end
        end
        if (!advance) begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one pipelined keyed ALU between requesters: round-robin issue, keyed result
// routing, one outstanding op per requester and a per-requester timeout watchdog.
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int unsigned ninputs = 4,
    parameter int unsigned timeout = ALU_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              en,
    input  logic [ninputs-1:0]                req_valid_i,
    output logic [ninputs-1:0]                req_ready_o,
    input  logic [ninputs*OPCODE_SIZE-1:0]    req_op_i,
    input  logic [ninputs*OPERAND_SIZE-1:0]   req_A_i,
    input  logic [ninputs*OPERAND_SIZE-1:0]   req_B_i,
    output logic [ninputs-1:0]                rsp_valid_o,
    output logic [OPERAND_SIZE-1:0]           rsp_O_o,
    output logic [ninputs-1:0]                timeout_o,
    output logic                              err_o,
    output logic [KEY_SIZE-1:0]               alu_key_o,
    output logic [OPCODE_SIZE-1:0]            alu_op_o,
    output logic [OPERAND_SIZE-1:0]           alu_A_o,
    output logic [OPERAND_SIZE-1:0]           alu_B_o,
    input  logic [KEY_SIZE-1:0]               alu_key_i,
    input  logic [OPERAND_SIZE-1:0]           alu_O_i
);

    localparam int unsigned TmrW = $clog2(timeout);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(timeout - 1);

    logic [ninputs-1:0]      busy_q;
    logic [TmrW-1:0]         tmr_q [ninputs];
    logic [ninputs-1:0]      eligible, grant, issue, hit, expire;
    logic                    any_issue, stray;
    logic [KEY_SIZE-1:0]     sel_key;
    logic [OPCODE_SIZE-1:0]  sel_op;
    logic [OPERAND_SIZE-1:0] sel_a, sel_b;

    assign eligible = req_valid_i & ~busy_q & {ninputs{en}};

    rr_arbiter #(
        .n (ninputs)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .req     (eligible),
        .advance (any_issue),
        .grant   (grant)
    );

    // Ready is forced low during reset/clear so no requester sees a phantom transfer.
    assign req_ready_o = (rst || clr) ? '0 : grant;
    assign issue       = req_ready_o & req_valid_i;
    assign any_issue   = |issue;

    always_comb begin
        sel_key = '0;
        sel_op  = '0;
        sel_a   = '0;
        sel_b   = '0;
        hit     = '0;
        expire  = '0;
        for (int i = 0; i < int'(ninputs); i++) begin
            if (issue[i]) begin
                sel_key = key_of(i);
                sel_op  = req_op_i[i*OPCODE_SIZE +: OPCODE_SIZE];
                sel_a   = req_A_i[i*OPERAND_SIZE +: OPERAND_SIZE];
                sel_b   = req_B_i[i*OPERAND_SIZE +: OPERAND_SIZE];
            end
            hit[i]    = busy_q[i] && (alu_key_i == key_of(i));
            // A result arriving on the last timer cycle beats the watchdog.
            expire[i] = busy_q[i] && !hit[i] && (tmr_q[i] == TmrLast);
        end
        stray = (alu_key_i != '0) && (hit == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_key_o   <= '0;
            alu_op_o    <= '0;
            alu_A_o     <= '0;
            alu_B_o     <= '0;
            rsp_valid_o <= '0;
            rsp_O_o     <= '0;
            timeout_o   <= '0;
            err_o       <= 1'b0;
            busy_q      <= '0;
            for (int i = 0; i < int'(ninputs); i++) tmr_q[i] <= '0;
        end else if (clr) begin
            alu_key_o   <= '0;
            alu_op_o    <= '0;
            alu_A_o     <= '0;
            alu_B_o     <= '0;
            rsp_valid_o <= '0;
            rsp_O_o     <= '0;
            timeout_o   <= '0;
            err_o       <= 1'b0;
            busy_q      <= '0;
            for (int i = 0; i < int'(ninputs); i++) tmr_q[i] <= '0;
        end else begin
            alu_key_o <= sel_key;
            if (any_issue) begin
                alu_op_o <= sel_op;
                alu_A_o  <= sel_a;
                alu_B_o  <= sel_b;
            end
            rsp_valid_o <= hit;
            if (|hit) begin
                rsp_O_o <= alu_O_i;
            end
            timeout_o <= expire;
            err_o     <= stray;
            for (int i = 0; i < int'(ninputs); i++) begin
                if (issue[i]) begin
                    busy_q[i] <= 1'b1;
                    tmr_q[i]  <= '0;
                end else if (hit[i] || expire[i]) begin
                    busy_q[i] <= 1'b0;
                    tmr_q[i]  <= '0;
                end else if (busy_q[i]) begin
                    tmr_q[i] <= tmr_q[i] + TmrW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: 3-stage echo ALU model, table vectors, scoreboard and
// hand-written sequences for reset, fairness, timeout, stray keys, clear and enable.
module tb_alu_scheduler;
    import alu_scheduler_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 16;
    localparam int unsigned LAT = 3;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      clr = 1'b0;
    logic                      en  = 1'b1;
    logic [N-1:0]              req_valid = '0;
    logic [N-1:0]              req_ready, rsp_valid, timeout_p;
    logic [N*OPCODE_SIZE-1:0]  req_op = '0;
    logic [N*OPERAND_SIZE-1:0] req_a = '0;
    logic [N*OPERAND_SIZE-1:0] req_b = '0;
    logic [OPERAND_SIZE-1:0]   rsp_o, alu_a, alu_b, alu_o;
    logic                      err;
    logic [KEY_SIZE-1:0]       alu_key_out, alu_key_in;
    logic [OPCODE_SIZE-1:0]    alu_op;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_scheduler #(
        .ninputs (N),
        .timeout (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .en          (en),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_A_i     (req_a),
        .req_B_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_O_o     (rsp_o),
        .timeout_o   (timeout_p),
        .err_o       (err),
        .alu_key_o   (alu_key_out),
        .alu_op_o    (alu_op),
        .alu_A_o     (alu_a),
        .alu_B_o     (alu_b),
        .alu_key_i   (alu_key_in),
        .alu_O_i     (alu_o)
    );

    function automatic logic [OPERAND_SIZE-1:0] alu_fn(input logic [OPCODE_SIZE-1:0] op,
                                                       input logic [OPERAND_SIZE-1:0] a,
                                                       input logic [OPERAND_SIZE-1:0] b);
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Echo ALU with LAT-cycle latency; drop_key swallows one key, inj_* overrides the return.
    logic [KEY_SIZE-1:0]     pk [LAT] = '{default: '0};
    logic [OPERAND_SIZE-1:0] po [LAT] = '{default: '0};
    logic [KEY_SIZE-1:0]     drop_key = '0;
    logic                    inj_en   = 1'b0;
    logic [KEY_SIZE-1:0]     inj_key  = '0;
    logic [OPERAND_SIZE-1:0] inj_o    = '0;

    always @(posedge clk) begin
        pk[0] <= (drop_key != '0 && alu_key_out == drop_key) ? '0 : alu_key_out;
        po[0] <= alu_fn(alu_op, alu_a, alu_b);
        for (int i = 1; i < int'(LAT); i++) begin
            pk[i] <= pk[i-1];
            po[i] <= po[i-1];
        end
    end

    assign alu_key_in = inj_en ? inj_key : pk[LAT-1];
    assign alu_o      = inj_en ? inj_o : po[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on observed transfer, pop on result strobe.
    typedef struct {
        int                      idx;
        logic [OPERAND_SIZE-1:0] res;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    bit   sb_mute = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst || clr) begin
            exp_q.delete();
        end else begin
            if (rsp_valid != '0 && !sb_mute) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", rsp_valid, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_owner", rsp_valid, N'(1) << e.idx);
                    check("sb_data", rsp_o, e.res);
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (req_valid[i] && req_ready[i] && drop_key != key_of(i)) begin
                    exp_q.push_back('{i, alu_fn(req_op[i*OPCODE_SIZE +: OPCODE_SIZE],
                                                req_a[i*OPERAND_SIZE +: OPERAND_SIZE],
                                                req_b[i*OPERAND_SIZE +: OPERAND_SIZE])});
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [OPCODE_SIZE-1:0] op,
                           input logic [OPERAND_SIZE-1:0] a, input logic [OPERAND_SIZE-1:0] b);
        req_op[i*OPCODE_SIZE +: OPCODE_SIZE]   = op;
        req_a[i*OPERAND_SIZE +: OPERAND_SIZE]  = a;
        req_b[i*OPERAND_SIZE +: OPERAND_SIZE]  = b;
    endtask

    // Waits (bounded) for any result strobe; returns the number of negedges waited.
    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            #2;
            if (rsp_valid != '0) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) check("rsp_wait", rsp_valid, '1);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        int                      idx;
        logic [OPCODE_SIZE-1:0]  op;
        logic [OPERAND_SIZE-1:0] a;
        logic [OPERAND_SIZE-1:0] b;
        logic [OPERAND_SIZE-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    int fair_exp[6] = '{0, 1, 2, 3, -1, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int seen;
        int stray_keys[2] = '{5, 7};

        vecs[0] = '{0, OpAdd, 32'd100,        32'd23,         32'd123};
        vecs[1] = '{1, OpSub, 32'd5,          32'd7,          32'hFFFF_FFFE};
        vecs[2] = '{3, OpAnd, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234};
        vecs[3] = '{2, OpOr,  32'hA000_0000,  32'h0000_0005,  32'hA000_0005};
        vecs[4] = '{1, OpXor, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
        vecs[5] = '{0, OpAdd, 32'hFFFF_FFFF,  32'd1,          32'd0};

        // Reset state, with every requester asking.
        @(negedge clk);
        req_valid = '1;
        #2;
        check("rst_ready", req_ready, '0);
        check("rst_key", alu_key_out, '0);
        check("rst_rsp", rsp_valid, '0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;

        // Round trip: requester 2 ADD 7+5.
        @(negedge clk);
        set_req(2, OpAdd, 32'd7, 32'd5);
        req_valid[2] = 1'b1;
        #2;
        check("rt_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid[2] = 1'b0;
        #2;
        check("rt_key", alu_key_out, 3);
        check("rt_op", alu_op, OpAdd);
        check("rt_a", alu_a, 7);
        check("rt_b", alu_b, 5);
        wait_rsp(cyc);
        check("rt_latency", cyc, 4);
        check("rt_rsp_valid", rsp_valid, 4'b0100);
        check("rt_rsp_o", rsp_o, 12);
        @(negedge clk);
        #2;
        check("rt_strobe_len", rsp_valid, '0);

        // Table-driven single operations.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            set_req(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b);
            req_valid[vecs[v].idx] = 1'b1;
            #2;
            check("vec_ready", req_ready, N'(1) << vecs[v].idx);
            @(negedge clk);
            req_valid = '0;
            wait_rsp(cyc);
            check("vec_owner", rsp_valid, N'(1) << vecs[v].idx);
            check("vec_result", rsp_o, vecs[v].exp);
        end

        // Asynchronous reset in the middle of traffic.
        @(negedge clk);
        for (int i = 0; i < int'(N); i++) set_req(i, OpAdd, 32'(i * 10), 32'd1);
        req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_ready", req_ready, '0);
        check("mid_rst_key", alu_key_out, '0);
        check("mid_rst_op", alu_op, '0);
        check("mid_rst_a", alu_a, '0);
        check("mid_rst_b", alu_b, '0);
        check("mid_rst_rsp", rsp_valid, '0);
        check("mid_rst_rsp_o", rsp_o, '0);
        check("mid_rst_timeout", timeout_p, '0);
        check("mid_rst_err", err, 1'b0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #2;
            if (err) seen = 1;
        end
        check("mid_rst_stray_err", seen, 1);

        // Fairness from ptr=0 with all requesters valid.
        @(negedge clk);
        for (int i = 0; i < int'(N); i++) set_req(i, OpAdd, 32'(i + 1), 32'd100);
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            #2;
            check("fair_grant", onehot_idx(req_ready), fair_exp[k]);
            if (k >= 1 && k <= 4) check("fair_key", alu_key_out, k);
            @(negedge clk);
        end
        req_valid = '0;
        repeat (10) @(negedge clk);

        // Timeout on a dropped result, then the late result is stray.
        drop_key = 3'd1;
        set_req(0, OpAdd, 32'd1, 32'd2);
        req_valid[0] = 1'b1;
        #2;
        check("to_ready", req_ready, 4'b0001);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[0] = 1'b0;
            #2;
            if (timeout_p != '0) begin
                cyc = c;
                break;
            end
        end
        check("to_cycle", cyc, 17);
        check("to_vec", timeout_p, 4'b0001);
        @(negedge clk);
        #2;
        check("to_pulse_len", timeout_p, '0);
        inj_en  = 1'b1;
        inj_key = 3'd1;
        inj_o   = 32'd99;
        @(negedge clk);
        inj_en = 1'b0;
        #2;
        check("late_err", err, 1'b1);
        check("late_no_rsp", rsp_valid, '0);

        // Result on the timer's last cycle wins over the timeout.
        @(negedge clk);
        sb_mute = 1'b1;
        set_req(0, OpSub, 32'd9, 32'd4);
        req_valid[0] = 1'b1;
        #2;
        check("race_ready", req_ready, 4'b0001);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[0] = 1'b0;
        end
        inj_en  = 1'b1;
        inj_key = 3'd1;
        inj_o   = 32'h5A5A;
        @(negedge clk);
        inj_en = 1'b0;
        #2;
        check("race_rsp", rsp_valid, 4'b0001);
        check("race_rsp_o", rsp_o, 32'h5A5A);
        check("race_no_timeout", timeout_p, '0);
        check("race_no_err", err, 1'b0);
        @(negedge clk);
        #2;
        check("race_no_late_timeout", timeout_p, '0);
        drop_key = '0;
        sb_mute  = 1'b0;

        // Out-of-range keys.
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            inj_en  = 1'b1;
            inj_key = KEY_SIZE'(stray_keys[s]);
            @(negedge clk);
            inj_en = 1'b0;
            #2;
            check("stray_err", err, 1'b1);
            check("stray_no_rsp", rsp_valid, '0);
            @(negedge clk);
            #2;
            check("stray_err_len", err, 1'b0);
        end

        // Enable low: no grants, pending result still routed.
        @(negedge clk);
        set_req(1, OpAdd, 32'd40, 32'd2);
        req_valid[1] = 1'b1;
        #2;
        check("en_first_ready", req_ready, 4'b0010);
        @(negedge clk);
        en = 1'b0;
        req_valid = '1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            #2;
            check("en_ready_low", req_ready, '0);
            if (rsp_valid == 4'b0010 && rsp_o == 32'd42) seen = 1;
            @(negedge clk);
        end
        check("en_rsp_routed", seen, 1);
        req_valid = '0;
        en = 1'b1;

        // Synchronous clear with an op in flight.
        @(negedge clk);
        set_req(3, OpOr, 32'h10, 32'h01);
        req_valid[3] = 1'b1;
        #2;
        check("clr_ready", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        #2;
        check("clr_key_before", alu_key_out, 4);
        clr = 1'b1;
        req_valid[0] = 1'b1;
        exp_q.delete();
        #1;
        check("clr_ready_low", req_ready, '0);
        @(negedge clk);
        clr = 1'b0;
        req_valid = '0;
        #2;
        check("clr_key", alu_key_out, '0);
        check("clr_a", alu_a, '0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #2;
            if (err) seen = 1;
            if (rsp_valid != '0) seen = 2;
        end
        check("clr_inflight_stray", seen, 1);

        repeat (5) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
